conv_interleaver_p: RTL
=======================

Name: conv_interleaver_p

Overview:
Parametrised convolutional interleaver/deinterleaver with BRANCHES branches, where branch b delays its data by b*UNIT_DEPTH visits (interleave) or (BRANCHES-1-b)*UNIT_DEPTH visits (deinterleave). It uses rdy/acpt handshakes on both sides, shares one delay-line array across all branches, and clears that array after reset. An optional sync input re-aligns the commutator to branch 0. It sits between the upstream byte source and the downstream consumer in the FEC chain. MODE selects the function, so one block serves both the TX interleaver and the RX deinterleaver.

Parameters:
WIDTH, 8, data width in bits.
BRANCHES, 12, number of commutator branches (>=2).
UNIT_DEPTH, 17, delay increment per branch, in branch visits (>=1).
MODE, 0, 0 = interleave (delay b*U); 1 = deinterleave (delay (BRANCHES-1-b)*U).
SYNC_ALIGN, 1, 1 = di_sync forces the commutator to branch 0; 0 = di_sync ignored.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  reset, synchronous, active-low.
enable  in  1  0 = accept nothing; the output register still drains.
di_rdy  in  1  upstream data valid.
di_acpt  out  1  block accepts di this cycle.
di  in  WIDTH  upstream data.
di_sync  in  1  marks di as a sync byte that belongs on branch 0.
do_rdy  out  1  output data valid.
do_acpt  in  1  downstream accepts do_data.
do_data  out  WIDTH  output data.
do_branch  out  BR_W  branch that produced do_data; BR_W = clog2(BRANCHES).
sync_err  out  1  one-cycle pulse: di_sync was accepted while the commutator was not on branch 0.
init_busy  out  1  high while the delay-line clear is running.

Behaviour:
- Constants:
  - TOTAL = UNIT_DEPTH*BRANCHES*(BRANCHES-1)/2 cells; 1122 at the defaults.
  - depth(b) = U*b (MODE 0) or U*(BRANCHES-1-b) (MODE 1).
  - base(b) = sum of depth(i) for i<b.
- Reset (reset_n low at a clk edge):
  - state=INIT, clr_addr=0, branch=0, all ptr[b]=0.
  - do_rdy=0, do_data=0, do_branch=0, sync_err=0, init_busy=1, di_acpt=0.
- INIT state:
  - Writes 0 to mem[clr_addr] each cycle and increments clr_addr.
  - After the write to cell TOTAL-1, moves to RUN; init_busy drops with the transition (TOTAL cycles after the reset release).
  - di_acpt=0 throughout.
  - reset_n low mid-INIT or mid-RUN restarts INIT from address 0.
- RUN state:
  - di_acpt = enable && (!do_rdy || do_acpt), combinational.
  - Accept = di_rdy && di_acpt. On accept with effective branch e:
    - depth(e)=0: do_data <= di.
    - Otherwise: do_data <= mem[base(e)+ptr[e]], then mem[base(e)+ptr[e]] <= di (old value read, then overwritten).
    - ptr[e] <= ptr[e]+1, wrapping to 0 at depth(e)-1.
    - do_rdy <= 1, do_branch <= e; latency is 1 cycle.
    - branch <= e+1, wrapping to 0 after BRANCHES-1.
- Effective branch e:
  - e = 0 if SYNC_ALIGN && di_sync; otherwise e = branch.
  - sync_err <= 1 for one cycle when SYNC_ALIGN && di_sync is accepted with branch != 0.
  - The skipped branches' pointers do not advance.
- Output register (1 entry):
  - Set on accept.
  - Cleared when do_rdy && do_acpt and there is no accept in the same cycle.
  - On a simultaneous pop and accept, it takes the new data and do_rdy stays 1 (full throughput, one byte per cycle).
- Stall:
  - do_rdy=1 with do_acpt=0: do_data and do_branch are held stable.
  - While di_rdy && !di_acpt, upstream must hold di stable (bench check).
- Register/width rules:
  - do_data is registered.
  - enable=0 stops acceptance only; pointers and branch are frozen.
  - ptr widths are clog2(max depth); address width is clog2(TOTAL).
- Steady state (after TOTAL cells have been filled): MODE0 followed by MODE1 with the same parameters is identity with an end-to-end delay of U*BRANCHES*(BRANCHES-1) accepted bytes.

Decomposition:
- Package conv_il_pkg holds:
  - functions f_depth(b, mode) and f_base(b, mode);
  - constant function f_total;
  - clog2 helper;
  - state enum {INIT, RUN}.
- Sub-module il_delay_mem (TOTAL x WIDTH array):
  - one write port;
  - combinational read;
  - read-old-before-write at the same address.
- The top level holds the FSM, commutator, pointers and handshake.

Test Plan:
- Reset then init: release reset_n → init_busy=1 and di_acpt=0 for exactly 1122 cycles, then di_acpt=1 with di_rdy=1 and enable=1.
- Interleave delay: MODE0 defaults, continuous stream di=0..255 repeating, do_acpt=1 → branch 0 outputs immediately (1 cycle). The byte entering branch 1 at accept n reappears at accept n+204. Branch 11 outputs 0x00 until its 187 cells have been visited.
- Round trip: MODE0 instance feeding a MODE1 instance, BRANCHES=3, U=2, random stalls on both sides (50% rdy, 50% acpt) → output equals input delayed by 12 bytes; do_data is stable whenever stalled.
- Backpressure: do_acpt=0 for 10 cycles with do_rdy=1 → di_acpt=0, do_data held. Release → one byte per cycle, no loss or duplication.
- Sync realign: SYNC_ALIGN=1, di_sync with 0xB8 sent while branch=5 → sync_err pulses for 1 cycle, do_branch=0, the next byte goes to branch 1. The same stimulus with SYNC_ALIGN=0 → no pulse and no realign.
- Reset mid-run and enable: reset_n low for 1 cycle mid-stream → do_rdy=0, INIT restarts and the outputs read 0 afterwards. enable=0 for 5 cycles → no accepts, the pending do_data still drains.

Source files
------------

// File: rtl/conv_interleaver_p_pkg.sv
// Shared definitions for the convolutional interleaver / deinterleaver.
//   state_t   : controller state (INIT clears the delay lines, RUN streams data)
//   f_clog2   : ceiling log2, never smaller than 1 so it can size a vector
//   f_depth   : delay-line length of branch b for the chosen mode
//   f_base    : first cell of branch b inside the shared delay-line array
//   f_total   : number of cells needed by all branches together
package conv_il_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int f_clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // mode 0 = interleave (branch b grows with b), mode 1 = deinterleave (mirror)
    function automatic int f_depth(input int b, input int branches,
                                   input int unit_depth, input int mode);
        return (mode == 0) ? unit_depth * b : unit_depth * (branches - 1 - b);
    endfunction

    function automatic int f_base(input int b, input int branches,
                                  input int unit_depth, input int mode);
        int sum = 0;
        for (int i = 0; i < b; i++) begin
            sum += f_depth(i, branches, unit_depth, mode);
        end
        return sum;
    endfunction

    function automatic int f_total(input int branches, input int unit_depth);
        return unit_depth * branches * (branches - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_interleaver_p_if.sv
// Stream bus of the interleaver: input side (di_*) and output side (do_*).
//   master : the environment (drives di_rdy/di/di_sync and do_acpt)
//   slave  : the interleaver (drives di_acpt and do_rdy/do_data/do_branch)
// Parameters: WIDTH = data width, BR_W = width of the branch index.
interface conv_interleaver_p_if #(
    parameter int WIDTH = 8,
    parameter int BR_W  = 4
);
    logic             di_rdy;
    logic             di_acpt;
    logic [WIDTH-1:0] di;
    logic             di_sync;
    logic             do_rdy;
    logic             do_acpt;
    logic [WIDTH-1:0] do_data;
    logic [BR_W-1:0]  do_branch;

    modport master (
        output di_rdy, di, di_sync, do_acpt,
        input  di_acpt, do_rdy, do_data, do_branch
    );

    modport slave (
        input  di_rdy, di, di_sync, do_acpt,
        output di_acpt, do_rdy, do_data, do_branch
    );
endinterface

// File: rtl/conv_interleaver_p_delay_mem.sv
// Shared delay-line storage for all commutator branches.
//   clk   : clock
//   we    : write enable
//   addr  : single address used for both read and write
//   wdata : data written at the clock edge
//   rdata : combinational read of the cell at addr; on a write cycle it
//           still shows the old contents, which is what the delay line needs
module il_delay_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1122,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end
endmodule

// File: rtl/conv_interleaver_p.sv
// Convolutional interleaver (MODE 0) / deinterleaver (MODE 1).
// A commutator steps through BRANCHES branches; branch b is a FIFO of
// depth(b) cells carved out of one shared array. After reset the array is
// cleared (init_busy high), then bytes stream through with one cycle latency.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   enable       : 0 blocks new input; a pending output still drains
//   bus (slave)  : di_rdy/di_acpt/di/di_sync in, do_rdy/do_acpt/do_data/do_branch out
//   sync_err     : one-cycle pulse when a sync byte arrives off branch 0
//   init_busy    : high while the delay-line array is being cleared
module conv_interleaver_p
    import conv_il_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BRANCHES   = 12,
    parameter int UNIT_DEPTH = 17,
    parameter int MODE       = 0,
    parameter int SYNC_ALIGN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    conv_interleaver_p_if.slave  bus,
    output logic                 sync_err,
    output logic                 init_busy
);
    localparam int BR_W      = f_clog2(BRANCHES);
    localparam int TOTAL     = f_total(BRANCHES, UNIT_DEPTH);
    localparam int AW        = f_clog2(TOTAL);
    localparam int MAX_DEPTH = UNIT_DEPTH * (BRANCHES - 1);
    localparam int PW        = f_clog2(MAX_DEPTH);

    localparam logic [AW-1:0]   LAST_ADDR   = AW'(TOTAL - 1);
    localparam logic [BR_W-1:0] LAST_BRANCH = BR_W'(BRANCHES - 1);

    // Per-branch constants: start cell, last pointer value, zero-depth flag
    logic [AW-1:0] base_arr [BRANCHES];
    logic [PW-1:0] last_arr [BRANCHES];
    logic          zero_arr [BRANCHES];

    for (genvar gi = 0; gi < BRANCHES; gi++) begin : g_branch
        localparam int D = f_depth(gi, BRANCHES, UNIT_DEPTH, MODE);
        localparam int B = f_base(gi, BRANCHES, UNIT_DEPTH, MODE);
        // a zero-depth branch never addresses memory; pin its base to 0 so
        // a base equal to TOTAL cannot overflow the address width
        assign base_arr[gi] = AW'((D == 0) ? 0 : B);
        assign last_arr[gi] = PW'((D == 0) ? 0 : D - 1);
        assign zero_arr[gi] = (D == 0);
    end

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic [BR_W-1:0]   branch_q, branch_d;
    logic [PW-1:0]     ptr_q [BRANCHES];
    logic [PW-1:0]     ptr_d [BRANCHES];
    logic              do_rdy_q, do_rdy_d;
    logic [WIDTH-1:0]  do_data_q, do_data_d;
    logic [BR_W-1:0]   do_branch_q, do_branch_d;
    logic              sync_err_q, sync_err_d;
    logic              init_busy_q, init_busy_d;

    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    logic              di_acpt_w;
    logic              accept_w;
    logic              sync_hit_w;
    logic [BR_W-1:0]   eff_w;

    // Input is taken only when the single output slot is free or being
    // emptied this same cycle, which keeps full one-byte-per-cycle throughput.
    assign di_acpt_w  = (state_q == RUN) && enable && (!do_rdy_q || bus.do_acpt);
    assign accept_w   = bus.di_rdy && di_acpt_w;
    assign sync_hit_w = (SYNC_ALIGN != 0) && bus.di_sync;
    // a sync byte always lands on branch 0; skipped branches keep their pointers
    assign eff_w      = sync_hit_w ? '0 : branch_q;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        branch_d    = branch_q;
        ptr_d       = ptr_q;
        do_rdy_d    = do_rdy_q;
        do_data_d   = do_data_q;
        do_branch_d = do_branch_q;
        sync_err_d  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = clr_addr_q;
        mem_wdata   = '0;

        case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (do_rdy_q && bus.do_acpt) begin
                    do_rdy_d = 1'b0;
                end
                if (accept_w) begin
                    do_rdy_d    = 1'b1;
                    do_branch_d = eff_w;
                    sync_err_d  = sync_hit_w && (branch_q != '0);
                    if (zero_arr[eff_w]) begin
                        do_data_d = bus.di;
                    end else begin
                        // the cell holds the byte that entered this branch
                        // depth(e) visits ago; emit it and store the new one
                        mem_addr  = base_arr[eff_w] + AW'(ptr_q[eff_w]);
                        do_data_d = mem_rdata;
                        mem_we    = 1'b1;
                        mem_wdata = bus.di;
                    end
                    ptr_d[eff_w] = (ptr_q[eff_w] == last_arr[eff_w]) ? '0
                                                                     : ptr_q[eff_w] + 1'b1;
                    branch_d     = (eff_w == LAST_BRANCH) ? '0 : eff_w + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        init_busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= INIT;
            clr_addr_q  <= '0;
            branch_q    <= '0;
            ptr_q       <= '{default: '0};
            do_rdy_q    <= 1'b0;
            do_data_q   <= '0;
            do_branch_q <= '0;
            sync_err_q  <= 1'b0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            branch_q    <= branch_d;
            ptr_q       <= ptr_d;
            do_rdy_q    <= do_rdy_d;
            do_data_q   <= do_data_d;
            do_branch_q <= do_branch_d;
            sync_err_q  <= sync_err_d;
            init_busy_q <= init_busy_d;
        end
    end

    il_delay_mem #(
        .WIDTH (WIDTH),
        .DEPTH (TOTAL),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.di_acpt   = di_acpt_w;
    assign bus.do_rdy    = do_rdy_q;
    assign bus.do_data   = do_data_q;
    assign bus.do_branch = do_branch_q;
    assign sync_err      = sync_err_q;
    assign init_busy     = init_busy_q;

endmodule
